// File: rtl/dm.sv
// Word-organised data memory for the single-cycle MIPS datapath: byte/halfword/word
// stores merged into the addressed word on the rising edge, combinational sign-extended loads.
module dm #(
  parameter int DEPTH  = 3072,
  parameter int ADDR_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        MemWrite,
  input  logic [1:0]  DMOp,
  output logic [31:0] rd
);

  localparam logic [1:0] OP_WORD = 2'b00;
  localparam logic [1:0] OP_BYTE = 2'b01;
  localparam logic [1:0] OP_HALF = 2'b10;

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic [31:0]       cur_word;
  logic [31:0]       wdata_d;
  logic              wr_en;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  assign idx      = addr[ADDR_W+1:2];
  assign in_range = ({2'b00, addr[31:2]} < 32'(DEPTH));
  // Guard the array index: idx can exceed DEPTH-1 when the address is out of range.
  assign cur_word = in_range ? mem_q[idx] : '0;
  assign wr_en    = MemWrite && in_range && (DMOp != 2'b11);

  assign byte_sel = cur_word[{addr[1:0], 3'b000} +: 8];
  assign half_sel = cur_word[{addr[1], 4'b0000} +: 16];

  // Sub-word stores merge into the current word so untouched lanes are preserved.
  always_comb begin
    wdata_d = cur_word;
    case (DMOp)
      OP_WORD: wdata_d = wd;
      OP_BYTE: wdata_d[{addr[1:0], 3'b000} +: 8] = wd[7:0];
      OP_HALF: wdata_d[{addr[1], 4'b0000} +: 16] = wd[15:0];
      default: wdata_d = cur_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= wdata_d;
`ifndef SYNTHESIS
      $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, wdata_d);
`endif
    end
  end

  always_comb begin
    rd = '0;
    if (in_range) begin
      case (DMOp)
        OP_WORD: rd = cur_word;
        OP_BYTE: rd = {{24{byte_sel[7]}}, byte_sel};
        OP_HALF: rd = {{16{half_sel[15]}}, half_sel};
        default: rd = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dm.sv
// Self-checking bench for dm: directed scenarios plus random traffic against a
// little-endian byte-array model of the 12 KiB memory.
module tb_dm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc, addr, wd;
  logic        MemWrite;
  logic [1:0]  DMOp;
  logic [31:0] rd;

  int errs  = 0;
  int n_chk = 0;

  logic [7:0] mb [12288];

  dm dut (
    .clk(clk), .reset(reset), .pc(pc), .addr(addr), .wd(wd),
    .MemWrite(MemWrite), .DMOp(DMOp), .rd(rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a, input logic [1:0] op);
    int b;
    if (op == 2'b11 || a >= 32'h3000) return 32'h0;
    case (op)
      2'b00: begin
        b = int'(a & ~32'h3);
        return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
      end
      2'b01: begin
        b = int'(a);
        return {{24{mb[b][7]}}, mb[b]};
      end
      default: begin
        b = int'(a & ~32'h1);
        return {{16{mb[b+1][7]}}, mb[b+1], mb[b]};
      end
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 12288; i++) mb[i] = 8'h00;
  endtask

  task automatic model_write(input logic we, input logic [1:0] op,
                             input logic [31:0] a, input logic [31:0] d);
    int b;
    if (!we || op == 2'b11 || a >= 32'h3000) return;
    case (op)
      2'b00: begin
        b = int'(a & ~32'h3);
        for (int k = 0; k < 4; k++) mb[b+k] = d[8*k +: 8];
      end
      2'b01: mb[int'(a)] = d[7:0];
      default: begin
        b = int'(a & ~32'h1);
        mb[b]   = d[7:0];
        mb[b+1] = d[15:8];
      end
    endcase
  endtask

  // One clock of traffic: rd checked before the edge (old contents) and after it (new contents).
  task automatic step(input string tag, input logic rst, input logic we, input logic [1:0] op,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    reset = rst; MemWrite = we; DMOp = op; addr = a; wd = d; pc = p;
    #2;
    chk({tag, "_pre"}, rd, exp_rd(a, op));
    @(posedge clk);
    if (rst) model_clear();
    else model_write(we, op, a, d);
    #1;
    chk({tag, "_post"}, rd, exp_rd(a, op));
  endtask

  task automatic look(input string tag, input logic [31:0] a, input logic [1:0] op,
                      input logic [31:0] exp);
    reset = 1'b0; MemWrite = 1'b0; DMOp = op; addr = a; wd = 32'h0;
    #1;
    chk(tag, rd, exp);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  op;
    logic        we, rst;

    reset = 1'b1; MemWrite = 1'b1; DMOp = 2'b00; addr = 32'h8; wd = 32'hDEAD_BEEF; pc = 32'h3000;
    model_clear();
    @(posedge clk); #1;
    reset = 1'b0; MemWrite = 1'b0;
    look("reset_w0", 32'h0, 2'b00, 32'h0);
    look("reset_w8", 32'h8, 2'b00, 32'h0);
    look("reset_top", 32'h2FFC, 2'b00, 32'h0);

    step("sw4", 1'b0, 1'b1, 2'b00, 32'h4, 32'h1234_5678, 32'h3000);
    look("lw4", 32'h4, 2'b00, 32'h1234_5678);
    step("sb7", 1'b0, 1'b1, 2'b01, 32'h7, 32'hFFFF_FF9A, 32'h3004);
    look("lw4_after_sb", 32'h4, 2'b00, 32'h9A34_5678);
    look("lb7", 32'h7, 2'b01, 32'hFFFF_FF9A);
    look("lb4", 32'h4, 2'b01, 32'h0000_0078);
    step("sh6", 1'b0, 1'b1, 2'b10, 32'h6, 32'h0000_8001, 32'h3008);
    look("lh6", 32'h6, 2'b10, 32'hFFFF_8001);
    look("lh5", 32'h5, 2'b10, 32'h0000_5678);
    look("lw6", 32'h6, 2'b00, 32'h8001_5678);

    step("nowe", 1'b0, 1'b0, 2'b00, 32'h4, 32'hFFFF_FFFF, 32'h300C);
    step("op11", 1'b0, 1'b1, 2'b11, 32'h4, 32'hFFFF_FFFF, 32'h3010);
    look("lw4_gated", 32'h4, 2'b00, 32'h8001_5678);
    step("oor", 1'b0, 1'b1, 2'b00, 32'h3000, 32'h5555_AAAA, 32'h3014);
    look("lw_oor", 32'h3000, 2'b00, 32'h0);
    look("lw0_oor_alias", 32'h0, 2'b00, 32'h0);

    step("rdw10", 1'b0, 1'b1, 2'b00, 32'h10, 32'hAAAA_5555, 32'h3018);
    look("lw10", 32'h10, 2'b00, 32'hAAAA_5555);

    step("midrst", 1'b1, 1'b1, 2'b00, 32'h8, 32'h1111_1111, 32'h301C);
    look("rst_lw4", 32'h4, 2'b00, 32'h0);
    look("rst_lw8", 32'h8, 2'b00, 32'h0);
    look("rst_lw10", 32'h10, 2'b00, 32'h0);

    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 9))
        0:       a = $urandom_range(32'h2FF0, 32'h3010);
        1:       a = $urandom;
        default: a = $urandom_range(0, 63);
      endcase
      d   = $urandom;
      op  = 2'($urandom_range(0, 3));
      we  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step("rand", rst, we, op, a, d, 32'h4000 + 32'(n) * 4);
    end

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule
